uivtc_line_reverse_buf: RTL

Ping-pong line buffer feeding the rotated-video window (window 1) of the 180° rotation VTC. Upstream, the DDR read path supplies each scaled line in forward pixel order, with lines already fetched bottom-to-top. This block replays each line in reverse pixel order, completing the 180° rotation. The read side is driven by the VTC's one-cycle-early window-1 enable, so data appears in the cycle the window-1 enable is high.

---
 rtl/uivtc_pkg.sv | 14 +
 rtl/uivtc_line_ram_sdp.sv | 28 ++
 rtl/uivtc_line_reverse_buf.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uivtc_pkg.sv
// Shared types for the rotated-video (window 1) line buffer.
// Bank state encoding and the default pixel width.
package uivtc_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_st_e;

    localparam int PIX_W_DEF = 32;

endpackage

// File: rtl/uivtc_line_ram_sdp.sv
// Simple dual-port line RAM, two banks selected by the address MSB.
// Registered read with one cycle of latency.
module uivtc_line_ram_sdp
    import uivtc_pkg::*;
#(
    parameter int DATA_W = PIX_W_DEF,
    parameter int ADDR_W = 10
) (
    input  logic              I_clk,
    input  logic              I_we,
    input  logic [ADDR_W:0]   I_waddr,
    input  logic [DATA_W-1:0] I_wdata,
    input  logic              I_re,
    input  logic [ADDR_W:0]   I_raddr,
    output logic [DATA_W-1:0] O_rdata
);

    logic [DATA_W-1:0] mem_q [2**(ADDR_W+1)];

    // Reader and writer never share a bank, so no collision handling.
    always_ff @(posedge I_clk) begin
        if (I_we)
            mem_q[I_waddr] <= I_wdata;
        if (I_re)
            O_rdata <= mem_q[I_raddr];
    end

endmodule

// File: rtl/uivtc_line_reverse_buf.sv
// Ping-pong line buffer replaying each line in reverse pixel order.
// Optional LINE_REVERSE_CFG_EN adds a per-frame forward/reverse select.
module uivtc_line_reverse_buf
    import uivtc_pkg::*;
#(
    parameter int H_PIXELS = 640,
    parameter int DATA_W   = PIX_W_DEF,
    parameter int ADDR_W   = 10
) (
    input  logic              I_vtc_clk,
    input  logic              I_vtc_rstn,
    input  logic              I_frame_start,
    input  logic              I_wr_valid,
    input  logic [DATA_W-1:0] I_wr_data,
    output logic              O_wr_ready,
    input  logic              I_rd_en,
`ifdef LINE_REVERSE_CFG_EN
    input  logic              I_reverse_en,
`endif
    output logic [DATA_W-1:0] O_rd_data,
    output logic              O_rd_valid,
    output logic [1:0]        O_bank_full,
    output logic              O_underflow,
    output logic              O_overflow
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_PIXELS - 1);

    bank_st_e          st_q [2];
    bank_st_e          st_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic              unf_q, unf_d;
    logic              ovf_q, ovf_d;
    logic              rdy_en_q;
    logic              rev;
    logic              wr_acc, rd_live, rd_acc;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] ram_q;

`ifdef LINE_REVERSE_CFG_EN
    logic rev_q, rev_d;

    always_comb begin
        rev_d = rev_q;
        if (I_frame_start)
            rev_d = I_reverse_en;
    end

    always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
        if (!I_vtc_rstn)
            rev_q <= 1'b1;
        else
            rev_q <= rev_d;
    end

    assign rev = rev_q;
`else
    assign rev = 1'b1;
`endif

    assign O_wr_ready = rdy_en_q & ~I_frame_start &
                        (st_q[wr_bank_q] == EMPTY ||
                         st_q[wr_bank_q] == FILLING);
    assign wr_acc  = I_wr_valid & O_wr_ready;
    assign rd_live = st_q[rd_bank_q] == FULL ||
                     st_q[rd_bank_q] == DRAINING;
    assign rd_acc  = I_rd_en & rd_live & ~I_frame_start;
    assign rd_addr = rev ? LAST - rd_cnt_q : rd_cnt_q;

    always_comb begin
        st_d       = st_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        rd_valid_d = rd_acc;
        ovf_d      = ovf_q | (I_wr_valid & ~O_wr_ready);
        unf_d      = unf_q | (I_rd_en & ~rd_live);
        if (wr_acc) begin
            if (wr_cnt_q == LAST) begin
                st_d[wr_bank_q] = FULL;
                wr_cnt_d        = '0;
                wr_bank_d       = ~wr_bank_q;
            end else begin
                st_d[wr_bank_q] = FILLING;
                wr_cnt_d        = wr_cnt_q + 1'b1;
            end
        end
        if (rd_acc) begin
            if (rd_cnt_q == LAST) begin
                st_d[rd_bank_q] = EMPTY;
                rd_cnt_d        = '0;
                rd_bank_d       = ~rd_bank_q;
            end else begin
                st_d[rd_bank_q] = DRAINING;
                rd_cnt_d        = rd_cnt_q + 1'b1;
            end
        end
        // Frame boundary discards everything in flight.
        if (I_frame_start) begin
            st_d[0]    = EMPTY;
            st_d[1]    = EMPTY;
            wr_bank_d  = 1'b0;
            rd_bank_d  = 1'b0;
            wr_cnt_d   = '0;
            rd_cnt_d   = '0;
            rd_valid_d = 1'b0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
        end
    end

    always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
        if (!I_vtc_rstn) begin
            st_q[0]    <= EMPTY;
            st_q[1]    <= EMPTY;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
            unf_q      <= 1'b0;
            ovf_q      <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            st_q       <= st_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_valid_q <= rd_valid_d;
            unf_q      <= unf_d;
            ovf_q      <= ovf_d;
            rdy_en_q   <= 1'b1;
        end
    end

    uivtc_line_ram_sdp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .I_clk   (I_vtc_clk),
        .I_we    (wr_acc),
        .I_waddr ({wr_bank_q, wr_cnt_q}),
        .I_wdata (I_wr_data),
        .I_re    (rd_acc),
        .I_raddr ({rd_bank_q, rd_addr}),
        .O_rdata (ram_q)
    );

    // RAM output is stale on idle cycles; hold the port at zero then.
    assign O_rd_data   = rd_valid_q ? ram_q : '0;
    assign O_rd_valid  = rd_valid_q;
    assign O_bank_full = {st_q[1] == FULL, st_q[0] == FULL};
    assign O_underflow = unf_q;
    assign O_overflow  = ovf_q;

endmodule
